issue_unit: RTL
===============

// Module: issue_unit
// PURPOSE
//  Issue scheduler that sits directly upstream of the reservation stations (one RS per pipelined FU).
//  Each cycle it picks at most one ready RS, round-robin, and asserts that RS's issue strobe.
//  It tracks the issued op through its fixed FU latency on a single shared result bus (CDB).
//  It then broadcasts wakeup/wakeup_tag/wakeup_value to all RSs exactly FU_LAT cycles after the grant.
// PARAMETERS
//  NUM_RS   2         number of RS/FU pairs
//  MAX_LAT  4         maximum FU latency, in cycles; sets the pending-slot depth
//  FU_LAT   '{1,2}    per-RS FU latency; each entry must be in 1..MAX_LAT (elaboration assertion)
// PORTS
//  clk           in   1                      clock
//  reset         in   1                      synchronous, active-high
//  rs_insn_ready in   NUM_RS                 RS i holds a ready insn
//  rs_dst_tag    in   NUM_RS x ROB_TAG_LEN   dst tag of the oldest ready insn of RS i
//  fu_result     in   NUM_RS x XLEN          FU i result, valid in the cycle its wakeup fires
//  rs_issue      out  NUM_RS                 one-hot or zero; combinational; RS samples it at posedge
//  wakeup        out  1                      CDB broadcast valid
//  wakeup_tag    out  ROB_TAG_LEN            tag being woken
//  wakeup_value  out  XLEN                   value of the woken tag
//  wakeup_rs     out  clog2(NUM_RS)          source FU index, for debug/ROB
// BEHAVIOUR
//  - State:
//    - pend[1..MAX_LAT] slots, each {valid, rs_idx, tag}.
//    - rr_ptr, clog2(NUM_RS) bits.
//  - Eligibility: RS i is eligible in cycle t iff rs_insn_ready[i] && !pend[FU_LAT[i]+1].valid.
//    - pend[MAX_LAT+1] is always treated as free.
//    - This ensures no two ops reach pend[1] in the same cycle.
//  - Grant: the first eligible RS scanning from rr_ptr upward, wrapping modulo NUM_RS.
//    - rs_issue[g]=1 for that RS only; all zeros if none is eligible.
//  - Every posedge:
//    - pend[k] <= pend[k+1] for k=1..MAX_LAT-1, and pend[MAX_LAT] <= invalid.
//    - On a grant g, pend[FU_LAT[g]] <= {1, g, rs_dst_tag[g]}; this overrides the shift, and eligibility guarantees the slot is free.
//    - On a grant g, rr_ptr <= (g+1) mod NUM_RS; with no grant, rr_ptr holds.
//  - Latency: a grant in cycle t gives wakeup=1 in cycle t+FU_LAT[g].
//  - CDB outputs in that cycle (combinational from pend[1]):
//    - wakeup = pend[1].valid
//    - wakeup_tag = pend[1].tag
//    - wakeup_value = fu_result[pend[1].rs_idx]
//    - wakeup_rs = pend[1].rs_idx
//  - When wakeup=0, wakeup_tag, wakeup_value and wakeup_rs are driven to 0 (no X on the bus).
//  - Reset:
//    - All pend slots are invalidated and rr_ptr=0.
//    - rs_issue=0 while reset is high.
//    - wakeup=0 in the first cycle after reset.
//    - Reset mid-operation drops all in-flight wakeups.
//  - Simultaneous events: grant and wakeup in the same cycle are independent.
//    - An RS woken in cycle t may be granted in cycle t only if it raised rs_insn_ready combinationally.
//  - Blocked ready RS: rs_issue stays 0; the RS keeps its insn; it is re-evaluated next cycle.
//  - No starvation: rr_ptr advances past each grantee.
//  - A CDB-blocked RS is retried once the conflicting slot drains.
// CONFIGURATION
//  ISSUE_UNIT_STATS_EN defined:
//    - Adds outputs stat_issued (32b) and stat_cdb_stall (32b).
//    - stat_issued increments once per grant.
//    - stat_cdb_stall increments in each cycle where some RS is ready but none is eligible.
//    - Both counters are cleared on reset and saturate at all-ones.
//  ISSUE_UNIT_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  issue_pkg (shared package):
//    - ISSUE_SLOT typedef {valid, rs_idx, tag}.
//    - RS_IDX_W = $clog2(NUM_RS).
//    - ROB_TAG_LEN and XLEN come from the existing headers.
//  rr_arbiter (sub-module): parameter N; ports req[N], ptr -> gnt[N] one-hot, gnt_valid, gnt_idx; purely combinational.
//  issue_unit owns the pend shift register, the eligibility mask, rr_ptr, the CDB mux and the optional counters.
// TESTING
//  Config for scenarios 1-5: NUM_RS=2, FU_LAT='{1,2}, MAX_LAT=4.
//  1 Reset held 2 cycles with RS0 ready -> rs_issue=0 during reset; wakeup=0 and rr_ptr=0 in the cycle after release.
//  2 RS0 ready, tag=5, fu_result[0]=0x1234 in cycle t -> rs_issue=2'b01 at t; at t+1 wakeup=1, tag=5, value=0x1234, wakeup_rs=0.
//  3 RS0 and RS1 ready every cycle -> grants alternate 0,1,0,1,...
//    - Every wakeup appears exactly FU_LAT cycles after its grant.
//    - Never two wakeups in one cycle.
//  4 CDB conflict: RS1 (tag 7) granted at t -> at t+1 only RS0 ready -> RS0 blocked at t+1 (its slot is occupied).
//    - RS0 granted at t+2.
//    - wakeup tag 7 at t+2; RS0's wakeup at t+3.
//  5 Reset asserted at t+1 after an RS1 grant at t -> no wakeup for tag 7 at t+2 or later.
//  6 ISSUE_UNIT_STATS_EN, run of scenario 4 -> stat_issued=2, stat_cdb_stall=1.
//    - Rebuild without the macro -> identical rs_issue/wakeup trace.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared definitions for the issue scheduler.
//   ROB_TAG_LEN / XLEN : tag and datapath widths used across the core
//   NUM_RS_DEF         : default number of RS/FU pairs
//   MAX_LAT_DEF        : default maximum FU latency (pending-slot depth)
//   RS_IDX_W           : width of an RS index
//   ISSUE_SLOT         : one in-flight op waiting for its CDB cycle
package issue_pkg;

  localparam int ROB_TAG_LEN = 6;
  localparam int XLEN        = 32;
  localparam int NUM_RS_DEF  = 2;
  localparam int MAX_LAT_DEF = 4;
  localparam int RS_IDX_W    = (NUM_RS_DEF > 1) ? $clog2(NUM_RS_DEF) : 1;

  typedef struct packed {
    logic                   valid;
    logic [RS_IDX_W-1:0]    rs_idx;
    logic [ROB_TAG_LEN-1:0] tag;
  } ISSUE_SLOT;

endpackage

// File: rtl/issue_unit_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i       : request vector
//   ptr_i       : highest-priority index for this cycle
//   gnt_o       : one-hot grant (zero when nothing requests)
//   gnt_valid_o : some request was granted
//   gnt_idx_o   : index of the granted request
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic         gnt_valid_o,
  output logic [W-1:0] gnt_idx_o
);

  // Two passes: first the requesters at or above the pointer, then wrap
  // around to the ones below it. The first hit in scan order wins.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_valid_o && req_i[i] && (W'(i) >= ptr_i)) begin
        gnt_valid_o = 1'b1;
        gnt_o[i]    = 1'b1;
        gnt_idx_o   = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!gnt_valid_o && req_i[i]) begin
        gnt_valid_o = 1'b1;
        gnt_o[i]    = 1'b1;
        gnt_idx_o   = W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_unit.sv
// Issue scheduler feeding one pipelined FU per reservation station.
// Picks at most one ready RS per cycle (round-robin) and schedules its
// result onto the single shared CDB exactly FU_LAT[rs] cycles later.
//   clk, reset         : clock, synchronous active-high reset
//   rs_insn_ready_i    : RS i holds a ready instruction
//   rs_dst_tag_i       : packed dst tags, RS i at [i*ROB_TAG_LEN +: ROB_TAG_LEN]
//   fu_result_i        : packed FU results, FU i at [i*XLEN +: XLEN]
//   rs_issue_o         : one-hot/zero issue strobe, combinational
//   wakeup_o           : CDB broadcast valid
//   wakeup_tag_o       : tag being woken (0 when idle)
//   wakeup_value_o     : value of the woken tag (0 when idle)
//   wakeup_rs_o        : source FU index (0 when idle)
// Optional feature, macro ISSUE_UNIT_STATS_EN:
//   stat_issued_o      : saturating count of grants
//   stat_cdb_stall_o   : saturating count of cycles with a ready RS but no grant
module issue_unit
  import issue_pkg::*;
#(
  parameter int NUM_RS          = NUM_RS_DEF,
  parameter int MAX_LAT         = MAX_LAT_DEF,
  parameter int FU_LAT [NUM_RS] = '{1, 2}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RS-1:0]        rs_insn_ready_i,
  input  logic [NUM_RS*ROB_TAG_LEN-1:0] rs_dst_tag_i,
  input  logic [NUM_RS*XLEN-1:0]   fu_result_i,
  output logic [NUM_RS-1:0]        rs_issue_o,
  output logic                     wakeup_o,
  output logic [ROB_TAG_LEN-1:0]   wakeup_tag_o,
  output logic [XLEN-1:0]          wakeup_value_o,
  output logic [RS_IDX_W-1:0]      wakeup_rs_o
`ifdef ISSUE_UNIT_STATS_EN
  ,
  output logic [31:0]              stat_issued_o,
  output logic [31:0]              stat_cdb_stall_o
`endif
);

  ISSUE_SLOT           pend_q [1:MAX_LAT];
  ISSUE_SLOT           pend_d [1:MAX_LAT];
  logic [RS_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_RS-1:0]   slot_busy;
  logic [NUM_RS-1:0]   req;
  logic [NUM_RS-1:0]   gnt;
  logic                gnt_valid;
  logic [RS_IDX_W-1:0] gnt_idx;

  if ($clog2(NUM_RS) > RS_IDX_W) begin : g_bad_num_rs
    $error("issue_unit: NUM_RS=%0d does not fit the package RS index width", NUM_RS);
  end

  // An RS with latency L would land in pend[L] next cycle; whatever sits in
  // pend[L+1] now shifts into that same slot, so it must be empty. Slots
  // beyond MAX_LAT never exist and therefore never block.
  for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
    if (FU_LAT[i] < 1 || FU_LAT[i] > MAX_LAT) begin : g_bad_lat
      $error("issue_unit: FU_LAT[%0d]=%0d outside 1..%0d", i, FU_LAT[i], MAX_LAT);
    end
    if (FU_LAT[i] < MAX_LAT) begin : g_chk
      assign slot_busy[i] = pend_q[FU_LAT[i]+1].valid;
    end else begin : g_free
      assign slot_busy[i] = 1'b0;
    end
  end

  // Reset masks every request so no strobe escapes while reset is high.
  assign req = rs_insn_ready_i & ~slot_busy & {NUM_RS{~reset}};

  rr_arbiter #(
    .N (NUM_RS),
    .W (RS_IDX_W)
  ) u_arb (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign rs_issue_o = gnt;

  // Pending slots advance one step toward the CDB each cycle; a fresh grant
  // is dropped directly into the slot matching its FU latency.
  always_comb begin
    for (int k = 1; k < MAX_LAT; k++) begin
      pend_d[k] = pend_q[k+1];
    end
    pend_d[MAX_LAT] = '0;
    rr_ptr_d        = rr_ptr_q;
    for (int i = 0; i < NUM_RS; i++) begin
      if (gnt[i]) begin
        pend_d[FU_LAT[i]].valid  = 1'b1;
        pend_d[FU_LAT[i]].rs_idx = RS_IDX_W'(i);
        pend_d[FU_LAT[i]].tag    = rs_dst_tag_i[i*ROB_TAG_LEN +: ROB_TAG_LEN];
      end
    end
    if (gnt_valid) begin
      rr_ptr_d = (gnt_idx == RS_IDX_W'(NUM_RS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= MAX_LAT; k++) begin
        pend_q[k] <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int k = 1; k <= MAX_LAT; k++) begin
        pend_q[k] <= pend_d[k];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // CDB driver: head slot selects the FU result; the bus is forced to zero
  // when idle so downstream comparators never see stale tags.
  always_comb begin
    wakeup_o       = pend_q[1].valid;
    wakeup_tag_o   = '0;
    wakeup_value_o = '0;
    wakeup_rs_o    = '0;
    if (pend_q[1].valid) begin
      wakeup_tag_o = pend_q[1].tag;
      wakeup_rs_o  = pend_q[1].rs_idx;
      for (int i = 0; i < NUM_RS; i++) begin
        if (pend_q[1].rs_idx == RS_IDX_W'(i)) begin
          wakeup_value_o = fu_result_i[i*XLEN +: XLEN];
        end
      end
    end
  end

`ifdef ISSUE_UNIT_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic        stall_cycle;

  // A stall is a cycle where work exists but every ready RS is CDB-blocked.
  assign stall_cycle = (|rs_insn_ready_i) && !gnt_valid;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (gnt_valid && (stat_issued_q != '1)) begin
      stat_issued_d = stat_issued_q + 32'd1;
    end
    if (stall_cycle && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued_o    = stat_issued_q;
  assign stat_cdb_stall_o = stat_stall_q;
`endif

endmodule
